regfile_sb: RTL and testbench

//  Parametrised integer register file with N read ports, one write port, a busy-bit

---
 rtl/regfile_sb.sv | 139 +++++++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Integer register file with NRD combinational read ports, one write port,
//   a busy-bit scoreboard and a hardware clear sequence that runs after reset.
//   x0 is hardwired to zero and can never be marked busy.
//
//   Optional feature (macro REGFILE_BYPASS_EN):
//     defined   - a read of the register being written this cycle returns the
//                 write data and reports not-busy (unless it is re-issued in
//                 the same cycle).
//     undefined - reads return the stored value; new data appears next cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   ready        1 once the clear sequence has finished
//   rs_addr      read addresses, port i at [i*AW +: AW]
//   rs_data      read data, port i at [i*XLEN +: XLEN]
//   rs_busy      per-port busy bit of the addressed register
//   issue_valid  mark issue_addr busy
//   issue_addr   destination register of the issued instruction
//   rd_write     writeback strobe
//   rd_addr      writeback register
//   rd_data      writeback data
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          ready,
    input  logic [NRD*$clog2(NREGS)-1:0]  rs_addr,
    output logic [NRD*XLEN-1:0]           rs_data,
    output logic [NRD-1:0]                rs_busy,
    input  logic                          issue_valid,
    input  logic [$clog2(NREGS)-1:0]      issue_addr,
    input  logic                          rd_write,
    input  logic [$clog2(NREGS)-1:0]      rd_addr,
    input  logic [XLEN-1:0]               rd_data
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    logic [AW-1:0]     cnt_q;
    logic              ready_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic run;
    logic wr_en;
    logic iss_en;

    assign run    = (state_q == RUN);
    assign wr_en  = run && rd_write && (rd_addr != '0);
    assign iss_en = run && issue_valid && (issue_addr != '0);
    assign ready  = ready_q;

    // Clear sequencer: x0 is never stored, so the sweep starts at register 1
    // and hands over to RUN after the last register has been zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // Storage is not reset; the clear sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    // Scoreboard: the set is applied after the clear so that an issue to the
    // register being written back in the same cycle (a newer producer) wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[rd_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        logic          mute;

        assign a    = rs_addr[g*AW +: AW];
        assign mute = !run || (a == '0);
`ifdef REGFILE_BYPASS_EN
        assign hit  = wr_en && (rd_addr == a);
`else
        assign hit  = 1'b0;
`endif
        assign rs_data[g*XLEN +: XLEN] = mute ? '0 : (hit ? rd_data : regs_q[a]);
        // A forwarded register reads as free unless it is re-issued this cycle,
        // in which case the registered busy bit is reported unchanged.
        assign rs_busy[g] = mute ? 1'b0 :
                            (hit && !(iss_en && (issue_addr == a))) ? 1'b0 : busy_q[a];
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ready;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [NRD-1:0]       rs_busy;
    logic                 issue_valid;
    logic [AW-1:0]        issue_addr;
    logic                 rd_write;
    logic [AW-1:0]        rd_addr;
    logic [XLEN-1:0]      rd_data;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rd_write    (rd_write),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic            wr;
        logic [AW-1:0]   wa;
        logic [63:0]     wd;
        logic            iv;
        logic [AW-1:0]   ia;
        logic [AW-1:0]   a0;
        logic [AW-1:0]   a1;
        logic [63:0]     d0;
        logic            b0;
        logic [63:0]     d1;
        logic            b1;
    } vec_t;

    typedef struct {
        string        name;
        int           port;
        logic [63:0]  d;
        logic         b;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];

    function automatic vec_t V(input logic wr, input logic [AW-1:0] wa, input logic [63:0] wd,
                               input logic iv, input logic [AW-1:0] ia,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [63:0] d0, input logic b0,
                               input logic [63:0] d1, input logic b1);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [63:0] wd,
                         input logic iv, input logic [AW-1:0] ia,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_write    = wr;
        rd_addr     = wa;
        rd_data     = wd;
        issue_valid = iv;
        issue_addr  = ia;
        rs_addr     = {a1, a0};
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.name, " data"}, rs_data[e.port*XLEN +: XLEN], e.d);
            chk({e.name, " busy"}, {63'd0, rs_busy[e.port]}, {63'd0, e.b});
        end
    endtask

    // Entered at posedge+1; drives one cycle, checks the combinational reads
    // mid-cycle and returns at the following posedge+1.
    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        drive(v.wr, v.wa, v.wd, v.iv, v.ia, v.a0, v.a1);
        e.name = {name, " p0"}; e.port = 0; e.d = v.d0; e.b = v.b0; sbq.push_back(e);
        e.name = {name, " p1"}; e.port = 1; e.d = v.d1; e.b = v.b1; sbq.push_back(e);
        #4;
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count(input string name, input logic traffic);
        for (int k = 1; k <= NREGS - 1; k++) begin
            if (traffic && k <= 3)
                drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd9);
            else
                drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd5);
            #4;
            chk({name, " clear rs_data"}, rs_data[63:0] | rs_data[127:64], 64'd0);
            chk({name, " clear rs_busy"}, {62'd0, rs_busy}, 64'd0);
            @(posedge clk);
            #1;
            chk({name, " ready timing"}, {63'd0, ready}, (k >= NREGS - 1) ? 64'd1 : 64'd0);
        end
    endtask

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ready in reset", {63'd0, ready}, 64'd0);
        rst_n = 1'b1;
        clear_count("initial", 1'b1);

        //            wr  wa     wd           iv  ia     a0     a1     d0       b0  d1           b1
        tbl.push_back(V(1, 5'd5,  DB,          0, 5'd0,  5'd0,  5'd0,  64'd0,   0, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd5,  5'd5,  DB,      0, DB,          0));
        tbl.push_back(V(1, 5'd0,  64'hFFFF,    0, 5'd0,  5'd5,  5'd0,  DB,      0, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd0,  5'd0,  64'd0,   0, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       1, 5'd7,  5'd7,  5'd5,  64'd0,   0, DB,          0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd7,  5'd7,  64'd0,   1, 64'd0,       1));
        tbl.push_back(V(1, 5'd7,  64'h42,      0, 5'd0,  5'd5,  5'd5,  DB,      0, DB,          0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd7,  5'd0,  64'h42,  0, 64'd0,       0));
        tbl.push_back(V(1, 5'd7,  64'h77,      1, 5'd7,  5'd5,  5'd5,  DB,      0, DB,          0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd7,  5'd7,  64'h77,  1, 64'h77,      1));
        tbl.push_back(V(1, 5'd12, 64'hABC,     1, 5'd13, 5'd7,  5'd12, 64'h77,  1, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd12, 5'd13, 64'hABC, 0, 64'd0,       1));
        tbl.push_back(V(1, 5'd13, 64'h1313,    1, 5'd12, 5'd5,  5'd7,  DB,      0, 64'h77,      1));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd12, 5'd13, 64'hABC, 1, 64'h1313,    0));
        tbl.push_back(V(0, 5'd0,  64'd0,       1, 5'd0,  5'd0,  5'd0,  64'd0,   0, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd0,  5'd9,  64'd0,   0, 64'd0,       0));
        tbl.push_back(V(0, 5'd0,  64'd0,       0, 5'd0,  5'd0,  5'd0,  64'd0,   0, 64'd0,       0));
        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // Same-cycle write/read of one register.
        run_vec("byp issue x3", V(0, 5'd0, 64'd0, 1, 5'd3, 5'd3, 5'd3, 64'd0, 0, 64'd0, 0));
`ifdef REGFILE_BYPASS_EN
        run_vec("byp write x3", V(1, 5'd3, 64'h11, 0, 5'd0, 5'd3, 5'd5, 64'h11, 0, DB, 0));
        run_vec("byp wr+iss x3", V(1, 5'd3, 64'h22, 1, 5'd3, 5'd3, 5'd3, 64'h22, 0, 64'h22, 0));
`else
        run_vec("byp write x3", V(1, 5'd3, 64'h11, 0, 5'd0, 5'd3, 5'd5, 64'd0, 1, DB, 0));
        run_vec("byp wr+iss x3", V(1, 5'd3, 64'h22, 1, 5'd3, 5'd3, 5'd3, 64'h11, 0, 64'h11, 0));
`endif
        run_vec("byp after x3", V(0, 5'd0, 64'd0, 0, 5'd0, 5'd3, 5'd7, 64'h22, 1, 64'h77, 1));

        // Reset while running with x7 busy.
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd5);
        #1;
        chk("pre-reset x7 busy", {63'd0, rs_busy[0]}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("run reset ready", {63'd0, ready}, 64'd0);
        chk("run reset busy", {62'd0, rs_busy}, 64'd0);
        chk("run reset data", rs_data[127:64], 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk("partial clear ready", {63'd0, ready}, 64'd0);
        end

        // Reset again mid-clear (counter at 10).
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset ready", {63'd0, ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_count("restart", 1'b0);

        run_vec("post-reset x5/x7", V(0, 5'd0, 64'd0, 0, 5'd0, 5'd5, 5'd7, 64'd0, 0, 64'd0, 0));
        run_vec("post-reset x3/x13", V(0, 5'd0, 64'd0, 0, 5'd0, 5'd3, 5'd13, 64'd0, 0, 64'd0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
